buf_exec_seq: RTL and testbench

- Sequencer for one src/dst buffer pass of a fully-connected layer, driven by the host through the same register path as the buffer loaders.
- On `start`, it drives the src read port and the dst accumulate/writeback port:
  - `exec`/`ia` walk the input vector once per output.
  - After a MAC-pipeline delay, `outr` (with `accr` if accumulating) and `oa` are issued once per output.
- Owns ping-pong bank selection (bit 12) for both buffers and signals completion to the host.

---
 rtl/buf_exec_seq.sv | 142 ++++++++++++++
 tb/tb_buf_exec_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/buf_exec_seq.sv
// Sequencer for one src/dst buffer pass of a fully-connected layer.
// Optional `BUF_EXEC_SEQ_STALL_EN adds a stall input that freezes the pass.
module buf_exec_seq #(
    parameter int LAT = 4,
    parameter int AW  = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [11:0]   is,
    input  logic [11:0]   os,
    input  logic          sbank,
    input  logic          dbank,
    input  logic          acc_en,
`ifdef BUF_EXEC_SEQ_STALL_EN
    input  logic          stall,
`endif
    output logic          exec,
    output logic [AW-1:0] ia,
    output logic          first,
    output logic          outr,
    output logic          accr,
    output logic [AW-1:0] oa,
    output logic          busy,
    output logic          done
);

    localparam int CW = AW - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] is_l, os_l;
    logic [CW-1:0] icnt, ocnt;
    logic          sbank_l, dbank_l, acc_l;
    logic [LAT-1:0] pv;
    logic [CW-1:0]  pidx [LAT];
    logic [AW-1:0]  oa_q;
    logic           stall_w;
    logic           hold;
    logic           grp_end;
    logic           last_exec;

`ifdef BUF_EXEC_SEQ_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign hold      = stall_w && (state_q == S_RUN || state_q == S_DRAIN);
    assign exec      = (state_q == S_RUN) && !stall_w;
    assign grp_end   = (icnt == is_l);
    assign last_exec = exec && grp_end && (ocnt == os_l);
    assign ia        = {sbank_l, icnt};
    assign first     = exec && (icnt == '0);

    // A frozen pipe must not repeat its head strobe.
    assign outr = pv[LAT-1] && !hold;
    assign accr = outr && acc_l;
    assign oa   = outr ? {dbank_l, pidx[LAT-1]} : oa_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_exec) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pv == '0) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            is_l    <= '0;
            os_l    <= '0;
            sbank_l <= 1'b0;
            dbank_l <= 1'b0;
            acc_l   <= 1'b0;
            icnt    <= '0;
            ocnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                is_l    <= is;
                os_l    <= os;
                sbank_l <= sbank;
                dbank_l <= dbank;
                acc_l   <= acc_en;
                icnt    <= '0;
                ocnt    <= '0;
            end else if (exec) begin
                if (grp_end) begin
                    icnt <= '0;
                    ocnt <= ocnt + 1'b1;
                end else begin
                    icnt <= icnt + 1'b1;
                end
            end
        end
    end

    // Writeback delay line: one entry per output group, tagged with its index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv   <= '0;
            oa_q <= '0;
            for (int i = 0; i < LAT; i++) pidx[i] <= '0;
        end else begin
            if (outr) oa_q <= {dbank_l, pidx[LAT-1]};
            if (!hold) begin
                pv[0]   <= exec && grp_end;
                pidx[0] <= ocnt;
                for (int i = 1; i < LAT; i++) begin
                    pv[i]   <= pv[i-1];
                    pidx[i] <= pidx[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_buf_exec_seq.sv
// Randomized bench for buf_exec_seq against a per-cycle event model
// derived from pass geometry (exec, writeback and done timing).
module tb_buf_exec_seq;

    localparam int LAT = 4;
    localparam int AW  = 13;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [11:0]   is;
    logic [11:0]   os;
    logic          sbank;
    logic          dbank;
    logic          acc_en;
    logic          exec;
    logic [AW-1:0] ia;
    logic          first;
    logic          outr;
    logic          accr;
    logic [AW-1:0] oa;
    logic          busy;
    logic          done;
`ifdef BUF_EXEC_SEQ_STALL_EN
    logic          stall;
`endif

    int errors;
    int checks;
    logic [AW-1:0] oa_hold;

    buf_exec_seq #(.LAT(LAT), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is     (is),
        .os     (os),
        .sbank  (sbank),
        .dbank  (dbank),
        .acc_en (acc_en),
`ifdef BUF_EXEC_SEQ_STALL_EN
        .stall  (stall),
`endif
        .exec   (exec),
        .ia     (ia),
        .first  (first),
        .outr   (outr),
        .accr   (accr),
        .oa     (oa),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".exec"}, 32'(exec), 0);
        check({tag, ".first"}, 32'(first), 0);
        check({tag, ".outr"}, 32'(outr), 0);
        check({tag, ".accr"}, 32'(accr), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".oa"}, 32'(oa), 32'(oa_hold));
    endtask

    task automatic scramble_inputs();
        is     = 12'($urandom);
        os     = 12'($urandom);
        sbank  = 1'($urandom);
        dbank  = 1'($urandom);
        acc_en = 1'($urandom);
    endtask

    // Called #1 after a posedge; leaves time at #1 after the posedge
    // of the first idle cycle following done.
    task automatic run_pass(input int iv, input int ov, input bit sb,
                            input bit db, input bit acc, input int restart_at);
        int n, total, m, k, j;
        bit e_exec, e_outr;
        is = 12'(iv); os = 12'(ov);
        sbank = sb; dbank = db; acc_en = acc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        n = (iv + 1) * (ov + 1);
        total = n + LAT + 2;
        for (int r = 1; r <= total + 1; r++) begin
            j = r - 1;
            e_exec = (r <= n);
            m = r - LAT;
            e_outr = (m > 0) && (m % (iv + 1) == 0) && (m / (iv + 1) <= ov + 1);
            k = m / (iv + 1) - 1;
            if (e_outr) oa_hold = {db, 12'(k)};
            check("exec", 32'(exec), 32'(e_exec));
            check("first", 32'(first), 32'(e_exec && (j % (iv + 1) == 0)));
            if (e_exec) check("ia", 32'(ia), 32'({sb, 12'(j % (iv + 1))}));
            check("outr", 32'(outr), 32'(e_outr));
            check("accr", 32'(accr), 32'(e_outr && acc));
            check("oa", 32'(oa), 32'(oa_hold));
            check("busy", 32'(busy), 32'(r <= n + LAT + 1));
            check("done", 32'(done), 32'(r == total));
            if (r == restart_at) begin
                os = 12'd0;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        oa_hold = '0;
        rst_n = 1'b0;
        start = 1'b0;
        is = '0; os = '0; sbank = 0; dbank = 0; acc_en = 0;
`ifdef BUF_EXEC_SEQ_STALL_EN
        stall = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_quiet("rst");
        check("rst.ia", 32'(ia), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_pass(3, 1, 1, 0, 0, 0);
        run_pass(3, 1, 1, 1, 1, 0);
        run_pass(0, 5, 0, 1, 0, 0);
        run_pass(3, 1, 1, 0, 0, 3);

        // Abort in RUN at icnt==2.
        is = 12'd3; os = 12'd1; sbank = 1; dbank = 1; acc_en = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort.ia", 32'(ia), 32'h1002);
        rst_n = 1'b0;
        oa_hold = '0;
        #1;
        check_quiet("abort");
        check("abort.ia0", 32'(ia), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_quiet("post");
        end

        for (int t = 0; t < 20; t++) begin
            run_pass(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     (t % 3 == 0) ? 2 : 0);
        end

        run_pass(4095, 0, 1, 1, 1, 100);
        run_pass(0, 4095, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
